// File: rtl/ac_in_queue_pkg.sv
// ============================================================================
// Module      : ac_in_queue_pkg
// Description : Shared defaults and operating-mode encoding for the
//               accumulator input queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ac_in_queue_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    QUEUED = 1'b0,
    BYPASS = 1'b1
  } ac_mode_e;

endpackage

`default_nettype wire

// File: rtl/ac_in_fifo_ctrl.sv
// ============================================================================
// Module      : ac_in_fifo_ctrl
// Description : Pointer, occupancy and sticky error-flag control for the
//               accumulator input FIFO. Storage lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ac_in_fifo_ctrl
  import ac_in_queue_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          bypass,
  input  logic          accept,
  input  logic          take,
  output logic          wr_en,
  output logic          rd_en,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  ac_mode_e      w_mode;
  logic          w_push;
  logic          w_pop;
  logic          w_do_push;
  logic          w_do_pop;
  logic [CW-1:0] w_count_nxt;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_overflow;
  logic          r_underflow;

  assign w_mode = ac_mode_e'(bypass);
  assign w_push = (w_mode == QUEUED) && accept && !clear;
  assign w_pop  = (w_mode == QUEUED) && take && !clear;

  // A pop frees a slot on the same edge, so a full FIFO still accepts push+pop.
  assign w_do_pop    = w_pop && !r_empty;
  assign w_do_push   = w_push && (!r_full || w_do_pop);
  assign w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (w_push && r_full && !w_pop) r_overflow  <= 1'b1;
      if (w_pop && r_empty)           r_underflow <= 1'b1;
    end
  end

  assign wr_en     = w_do_push;
  assign rd_en     = w_do_pop;
  assign wr_ptr    = r_wr_ptr;
  assign rd_ptr    = r_rd_ptr;
  assign count     = r_count;
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: rtl/ac_in_queue.sv
// ============================================================================
// Module      : ac_in_queue
// Description : Accumulator input stage - DEPTH-entry operand FIFO with a
//               legacy single-word bypass latch and a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ac_in_queue
  import ac_in_queue_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] new_data,
  input  logic             accept,
  input  logic             bypass,
  input  logic             take,
  input  logic             clear,
  output logic [WIDTH-1:0] data,
  output logic             data_new,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  ac_mode_e         w_mode;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [PW-1:0]    w_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_data;
  logic             r_data_new;

  assign w_mode = ac_mode_e'(bypass);

  ac_in_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bypass    (bypass),
    .accept    (accept),
    .take      (take),
    .wr_en     (w_wr_en),
    .rd_en     (w_rd_en),
    .wr_ptr    (w_wr_ptr),
    .rd_ptr    (w_rd_ptr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_ptr] <= new_data;
  end

  // clear flushes the queue but deliberately keeps the last operand on data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= '0;
      r_data_new <= 1'b0;
    end else if (clear) begin
      r_data_new <= 1'b0;
    end else if (w_mode == BYPASS && accept) begin
      r_data     <= new_data;
      r_data_new <= 1'b1;
    end else if (w_rd_en) begin
      r_data     <= r_mem[w_rd_ptr];
      r_data_new <= 1'b1;
    end else begin
      r_data_new <= 1'b0;
    end
  end

  assign data     = r_data;
  assign data_new = r_data_new;

endmodule

`default_nettype wire

// File: tb/tb_ac_in_queue.sv
// ============================================================================
// Module      : tb_ac_in_queue
// Description : Scoreboard bench for ac_in_queue (WIDTH=8, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ac_in_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] new_data;
  logic             accept;
  logic             bypass;
  logic             take;
  logic             clear;
  logic [WIDTH-1:0] data;
  logic             data_new;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_fails  = 0;

  logic [WIDTH-1:0] m_fifo [$];
  logic [WIDTH-1:0] sb_q   [$];
  logic [WIDTH-1:0] m_data;
  logic             m_new;
  logic             m_ovf;
  logic             m_unf;

  ac_in_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .new_data  (new_data),
    .accept    (accept),
    .bypass    (bypass),
    .take      (take),
    .clear     (clear),
    .data      (data),
    .data_new  (data_new),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare after the edge.
  task automatic step(input logic rst, input logic byp, input logic acc,
                      input logic tk, input logic clr, input logic [WIDTH-1:0] nd);
    bit pop_ok;
    bit push_ok;
    logic [WIDTH-1:0] v;
    @(negedge clk);
    reset = rst; bypass = byp; accept = acc; take = tk; clear = clr; new_data = nd;
    m_new = 1'b0;
    if (rst) begin
      m_fifo.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_data = '0;
    end else if (clr) begin
      m_fifo.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (byp) begin
      if (acc) begin
        m_data = nd; m_new = 1'b1; sb_q.push_back(nd);
      end
    end else begin
      pop_ok  = tk && (m_fifo.size() > 0);
      push_ok = acc && ((m_fifo.size() < DEPTH) || pop_ok);
      if (acc && m_fifo.size() == DEPTH && !tk) m_ovf = 1'b1;
      if (tk && m_fifo.size() == 0) m_unf = 1'b1;
      if (pop_ok) begin
        v = m_fifo.pop_front(); m_data = v; m_new = 1'b1; sb_q.push_back(v);
      end
      if (push_ok) m_fifo.push_back(nd);
    end
    @(posedge clk);
    #1;
    check("data_new", 32'(data_new), 32'(m_new));
    if (m_new) begin
      if (sb_q.size() == 0) check("sb_underrun", 32'(1), 32'(0));
      else check("data_sb", 32'(data), 32'(sb_q.pop_front()));
    end
    check("data", 32'(data), 32'(m_data));
    check("count", 32'(count), 32'(m_fifo.size()));
    check("empty", 32'(empty), 32'(m_fifo.size() == 0));
    check("full", 32'(full), 32'(m_fifo.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  initial begin
    m_data = '0; m_new = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    reset = 1'b1; bypass = 1'b0; accept = 1'b0; take = 1'b0; clear = 1'b0; new_data = '0;

    // 1: reset held two cycles with accept asserted
    step(1, 0, 1, 0, 0, 8'h33);
    step(1, 0, 1, 0, 0, 8'h44);

    // 2: bypass latch - single load then idle
    step(0, 1, 1, 0, 0, 8'h01);
    step(0, 1, 0, 0, 0, 8'h02);
    step(0, 1, 0, 1, 0, 8'h02);
    check("bypass_hold", 32'(data), 32'h01);

    // 3: fill, overflow on fifth push, drain in order
    step(0, 0, 1, 0, 0, 8'h01);
    step(0, 0, 1, 0, 0, 8'h02);
    step(0, 0, 1, 0, 0, 8'h04);
    step(0, 0, 1, 0, 0, 8'h05);
    check("full_after_4", 32'(full), 32'(1));
    step(0, 0, 1, 0, 0, 8'h06);
    check("ovf_set", 32'(overflow), 32'(1));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 8'h00);
    check("drain_last", 32'(data), 32'h05);

    // 4: pointer wrap
    step(0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 8'(8'h10 + i));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 8'h00);
    check("wrap_empty", 32'(empty), 32'(1));

    // 5: full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 8'(8'h30 + i));
    step(0, 0, 1, 1, 0, 8'h07);
    check("fullpp_data", 32'(data), 32'h30);
    check("fullpp_ovf", 32'(overflow), 32'(0));

    // bypass leaves queued words frozen
    step(0, 1, 1, 1, 0, 8'hAA);
    step(0, 0, 0, 1, 0, 8'h00);
    check("frozen_pop", 32'(data), 32'h31);

    // 6: drain, underflow on empty take, push+pop on empty, then clear
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 0, 8'h00);
    check("unf_set", 32'(underflow), 32'(1));
    step(0, 0, 1, 1, 0, 8'h5A);
    step(0, 0, 0, 0, 1, 8'h00);
    check("clear_data_held", 32'(data), 32'h07);

    // random mix, including mid-stream reset
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) == 0),
           1'($urandom), 1'($urandom), ($urandom_range(0, 30) == 0), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
